egg_run_sequencer: RTL and testbench
====================================

EGG_RUN_SEQUENCER -- requirements
Module: egg_run_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 8, number of in_clk cycles cpu_rst_n is held low before a run.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, maximum in_clk cycles allowed in RUN.
REQ-003 SHALL have port in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port in_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  16  switch value for configuration loads.
REQ-006 SHALL have ports is_init_floors, is_init_resistance  input  1 each  level load strobes.
REQ-007 SHALL have port start_btn  input  1  level (already debounced); rising edge requests a run.
REQ-008 SHALL have port abort_btn  input  1  level; high cancels an active run.
REQ-009 SHALL have ports cpu_halt  input  1, cpu_attempt_count  input  32, cpu_broken_count  input  32, cpu_last_broken  input  1  CPU result interface.
REQ-010 SHALL have ports cfg_floors, cfg_resistance  output  16 each  registered CPU configuration.
REQ-011 SHALL have port cpu_rst_n  output  1  CPU reset, active-low.
REQ-012 SHALL have ports busy, done, err  output  1 each; err_code  output  2; last_broken  output  1.
REQ-013 SHALL have port run_cycles  output  32  in_clk cycles spent in RUN for the last run.
REQ-014 SHALL have port disp_data  output  32  value for the seven-segment driver.

Function
REQ-015 SHALL implement states IDLE, HOLD, RUN, DONE, ERR.
REQ-016 SHALL, in IDLE/DONE/ERR, load in_data into cfg_floors on is_init_floors, else into cfg_resistance on is_init_resistance (floors wins when both high), setting the matching valid flag; DONE/ERR return to IDLE on any load.
REQ-017 SHALL ignore load strobes in HOLD and RUN.
REQ-018 SHALL detect start as start_btn high this cycle and low the previous cycle; a held button produces one start.
REQ-019 SHALL, on start in IDLE or DONE: if both valid flags set and cfg_floors != 0, enter HOLD; else enter ERR with err_code 2'd1 (missing config) or 2'd2 (floors zero, checked after missing).
REQ-020 SHALL drive cpu_rst_n low in every state except RUN.
REQ-021 SHALL stay in HOLD exactly RST_HOLD cycles, then enter RUN with run counter cleared.
REQ-022 SHALL, in RUN, increment the run counter each cycle; on cpu_halt high, enter DONE and latch cpu_attempt_count, cpu_broken_count, cpu_last_broken, counter+1 in that cycle.
REQ-023 SHALL, in RUN without cpu_halt when counter equals TIMEOUT_CYCLES-1, enter ERR with err_code 2'd3; halt wins over timeout in the same cycle.
REQ-024 SHALL, on abort_btn high in HOLD or RUN, enter IDLE with results unchanged; abort has priority over halt and timeout.
REQ-025 SHALL ignore start in HOLD, RUN and ERR.
REQ-026 SHALL assert busy in HOLD and RUN, done in DONE, err in ERR; err_code holds its value until the next start or load clears it to 0.
REQ-027 SHALL drive disp_data = {attempt[15:0], broken[15:0]} latched results in DONE, else {cfg_floors, cfg_resistance}.
REQ-028 SHALL register all outputs except disp_data, which is a mux of registers.

Reset
REQ-029 SHALL, while in_rst low, force IDLE, cpu_rst_n 0, cfg registers, valid flags, latched results, run_cycles, err_code 0, busy/done/err/last_broken 0, regardless of in_clk.
REQ-030 SHALL, on reset mid-run, discard the run with no partial results.

Verification
REQ-031 Load floors 100, resistance 37, start, cpu_halt after 50 RUN cycles with attempt 8, broken 3 -> cpu_rst_n low 8 cycles, done=1, run_cycles=50, disp_data=0x00080003.
REQ-032 Start with only floors loaded -> err=1, err_code=1, cpu_rst_n stays 0; then load resistance -> IDLE, err=0.
REQ-033 Load floors 0, resistance 5, start -> err_code=2.
REQ-034 TIMEOUT_CYCLES=20, no halt -> ERR err_code=3 after 20 RUN cycles; halt and timeout same cycle -> DONE.
REQ-035 Abort in RUN cycle 10 -> IDLE next cycle, cpu_rst_n=0, previous results and disp_data source unchanged.
REQ-036 Assert in_rst low between clock edges during RUN -> outputs reach reset values immediately; start_btn held high across reset release produces no start.

Source files
------------

// File: rtl/egg_run_sequencer.sv
// Run sequencer for the egg-drop CPU: holds configuration, resets the CPU,
// times the run and latches its results for display.
module egg_run_sequencer #(
    parameter int          RST_HOLD       = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [15:0] in_data,
    input  logic        is_init_floors,
    input  logic        is_init_resistance,
    input  logic        start_btn,
    input  logic        abort_btn,
    input  logic        cpu_halt,
    input  logic [31:0] cpu_attempt_count,
    input  logic [31:0] cpu_broken_count,
    input  logic        cpu_last_broken,
    output logic [15:0] cfg_floors,
    output logic [15:0] cfg_resistance,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        last_broken,
    output logic [31:0] run_cycles,
    output logic [31:0] disp_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] RUN_LAST  = TIMEOUT_CYCLES - 32'd1;

    state_t      state_r, state_s;
    logic        start_prev_r;
    logic [31:0] hold_cnt_r, hold_cnt_s;
    logic [31:0] run_cnt_r, run_cnt_s;
    logic [15:0] floors_r, floors_s, res_r, res_s;
    logic        floors_vld_r, floors_vld_s, res_vld_r, res_vld_s;
    logic [31:0] attempt_r, attempt_s, broken_r, broken_s;
    logic        last_broken_r, last_broken_s;
    logic [31:0] run_cycles_r, run_cycles_s;
    logic [1:0]  err_code_r, err_code_s;
    logic        busy_r, done_r, err_r, cpu_rst_n_r;
    logic        start_s, load_s;

    assign start_s = start_btn & ~start_prev_r;
    assign load_s  = is_init_floors | is_init_resistance;

    // Next-state, configuration and result capture
    always_comb begin
        state_s       = state_r;
        hold_cnt_s    = hold_cnt_r;
        run_cnt_s     = run_cnt_r;
        floors_s      = floors_r;
        res_s         = res_r;
        floors_vld_s  = floors_vld_r;
        res_vld_s     = res_vld_r;
        attempt_s     = attempt_r;
        broken_s      = broken_r;
        last_broken_s = last_broken_r;
        run_cycles_s  = run_cycles_r;
        err_code_s    = err_code_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_s) begin
                    if (is_init_floors) begin
                        floors_s     = in_data;
                        floors_vld_s = 1'b1;
                    end else begin
                        res_s     = in_data;
                        res_vld_s = 1'b1;
                    end
                    err_code_s = 2'd0;
                    state_s    = ST_IDLE;
                end else if (start_s && (state_r != ST_ERR)) begin
                    if (!(floors_vld_r && res_vld_r)) begin
                        err_code_s = 2'd1;
                        state_s    = ST_ERR;
                    end else if (floors_r == 16'd0) begin
                        err_code_s = 2'd2;
                        state_s    = ST_ERR;
                    end else begin
                        err_code_s = 2'd0;
                        hold_cnt_s = 32'd0;
                        state_s    = ST_HOLD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_HOLD: begin
                if (abort_btn) begin
                    state_s = ST_IDLE;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    run_cnt_s = 32'd0;
                    state_s   = ST_RUN;
                end else begin
                    hold_cnt_s = hold_cnt_r + 32'd1;
                end
            end
            ST_RUN: begin
                // abort beats halt, halt beats timeout
                if (abort_btn) begin
                    state_s = ST_IDLE;
                end else if (cpu_halt) begin
                    attempt_s     = cpu_attempt_count;
                    broken_s      = cpu_broken_count;
                    last_broken_s = cpu_last_broken;
                    run_cycles_s  = run_cnt_r + 32'd1;
                    state_s       = ST_DONE;
                end else if (run_cnt_r == RUN_LAST) begin
                    err_code_s = 2'd3;
                    state_s    = ST_ERR;
                end else begin
                    run_cnt_s = run_cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, data and status registers
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_r       <= ST_IDLE;
            start_prev_r  <= 1'b1;
            hold_cnt_r    <= 32'd0;
            run_cnt_r     <= 32'd0;
            floors_r      <= 16'd0;
            res_r         <= 16'd0;
            floors_vld_r  <= 1'b0;
            res_vld_r     <= 1'b0;
            attempt_r     <= 32'd0;
            broken_r      <= 32'd0;
            last_broken_r <= 1'b0;
            run_cycles_r  <= 32'd0;
            err_code_r    <= 2'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            cpu_rst_n_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            start_prev_r  <= start_btn;
            hold_cnt_r    <= hold_cnt_s;
            run_cnt_r     <= run_cnt_s;
            floors_r      <= floors_s;
            res_r         <= res_s;
            floors_vld_r  <= floors_vld_s;
            res_vld_r     <= res_vld_s;
            attempt_r     <= attempt_s;
            broken_r      <= broken_s;
            last_broken_r <= last_broken_s;
            run_cycles_r  <= run_cycles_s;
            err_code_r    <= err_code_s;
            busy_r        <= (state_s == ST_HOLD) || (state_s == ST_RUN);
            done_r        <= (state_s == ST_DONE);
            err_r         <= (state_s == ST_ERR);
            cpu_rst_n_r   <= (state_s == ST_RUN);
        end
    end

    assign cfg_floors     = floors_r;
    assign cfg_resistance = res_r;
    assign cpu_rst_n      = cpu_rst_n_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign err_code       = err_code_r;
    assign last_broken    = last_broken_r;
    assign run_cycles     = run_cycles_r;
    assign disp_data      = (state_r == ST_DONE) ? {attempt_r[15:0], broken_r[15:0]}
                                                 : {floors_r, res_r};

endmodule

// File: tb/tb_egg_run_sequencer.sv
// Scoreboard bench for egg_run_sequencer: run outcomes are predicted when a
// start is issued and checked by a monitor when done or err rises.
module tb_egg_run_sequencer;

    localparam int RH = 8;
    localparam int TO = 60;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [15:0] in_data;
    logic        is_init_floors, is_init_resistance, start_btn, abort_btn;
    logic        cpu_halt, cpu_last_broken;
    logic [31:0] cpu_attempt_count, cpu_broken_count;
    logic [15:0] cfg_floors, cfg_resistance;
    logic        cpu_rst_n, busy, done, err, last_broken;
    logic [1:0]  err_code;
    logic [31:0] run_cycles, disp_data;

    egg_run_sequencer #(.RST_HOLD(RH), .TIMEOUT_CYCLES(32'(TO))) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_data(in_data),
        .is_init_floors(is_init_floors), .is_init_resistance(is_init_resistance),
        .start_btn(start_btn), .abort_btn(abort_btn), .cpu_halt(cpu_halt),
        .cpu_attempt_count(cpu_attempt_count), .cpu_broken_count(cpu_broken_count),
        .cpu_last_broken(cpu_last_broken), .cfg_floors(cfg_floors),
        .cfg_resistance(cfg_resistance), .cpu_rst_n(cpu_rst_n), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .last_broken(last_broken),
        .run_cycles(run_cycles), .disp_data(disp_data)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic        done;
        logic [1:0]  code;
        logic [31:0] cycles;
        logic        lb;
        logic [31:0] disp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: configuration, last results, outcome state (0 idle, 1 done, 2 err)
    logic [15:0] m_floors, m_res;
    logic        m_vf, m_vr, m_lb;
    logic [31:0] m_att, m_brk, m_cycles;
    int          m_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic model_reset();
        m_floors = 16'd0; m_res = 16'd0; m_vf = 1'b0; m_vr = 1'b0;
        m_att = 32'd0; m_brk = 32'd0; m_cycles = 32'd0; m_lb = 1'b0; m_state = 0;
    endtask

    task automatic load_floors(input logic [15:0] v);
        in_data = v; is_init_floors = 1'b1;
        tick();
        is_init_floors = 1'b0;
        m_floors = v; m_vf = 1'b1; m_state = 0;
        check("load_floors_val", cfg_floors, v);
        check("load_floors_err", {err, done, err_code}, 32'd0);
    endtask

    task automatic load_res(input logic [15:0] v);
        in_data = v; is_init_resistance = 1'b1;
        tick();
        is_init_resistance = 1'b0;
        m_res = v; m_vr = 1'b1; m_state = 0;
        check("load_res_val", cfg_resistance, v);
        check("load_res_err", {err, done, err_code}, 32'd0);
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    // counts the cycles cpu_rst_n stays low after a start that should launch a run
    task automatic wait_hold();
        int n;
        n = 1;
        while (cpu_rst_n == 1'b0 && n < RH + 20) begin
            tick();
            if (cpu_rst_n == 1'b0) n++;
        end
        check("hold_len", n, RH);
    endtask

    task automatic do_run(input int halt_at, input logic [31:0] att, input logic [31:0] brk,
                          input logic lb);
        exp_t e;
        int   n;
        int   exp_len;
        if (m_state == 2) begin
            press_start();
            tick();
            check("start_in_err_err", err, 1'b1);
            check("start_in_err_busy", busy, 1'b0);
            return;
        end
        e.done = 1'b0; e.cycles = m_cycles; e.lb = m_lb; e.disp = {m_floors, m_res};
        if (!(m_vf && m_vr) || m_floors == 16'd0) begin
            e.code = (m_vf && m_vr) ? 2'd2 : 2'd1;
            sb_q.push_back(e);
            m_state = 2;
            press_start();
            tick();
            check("cfg_err_rst", cpu_rst_n, 1'b0);
            check("cfg_err_busy", busy, 1'b0);
            return;
        end
        if (halt_at >= 1 && halt_at <= TO) begin
            e.done = 1'b1; e.code = 2'd0; e.cycles = 32'(halt_at); e.lb = lb;
            e.disp = {att[15:0], brk[15:0]};
            m_att = att; m_brk = brk; m_lb = lb; m_cycles = 32'(halt_at); m_state = 1;
            exp_len = halt_at;
        end else begin
            e.code = 2'd3; m_state = 2; exp_len = TO;
        end
        sb_q.push_back(e);
        press_start();
        wait_hold();
        n = 1;
        while (!(done || err) && n < TO + 10) begin
            if (n == halt_at) begin
                cpu_halt = 1'b1; cpu_attempt_count = att; cpu_broken_count = brk;
                cpu_last_broken = lb;
            end else begin
                cpu_halt = 1'b0; cpu_attempt_count = $urandom; cpu_broken_count = $urandom;
                cpu_last_broken = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        cpu_halt = 1'b0;
        check("run_len", n - 1, exp_len);
        check("post_run_rst", cpu_rst_n, 1'b0);
    endtask

    // abort at RUN cycle `at`, with a halt and an ignored load strobe thrown in
    task automatic abort_run(input int at);
        press_start();
        wait_hold();
        for (int i = 1; i <= at; i++) begin
            is_init_floors = (i == 5);
            in_data = m_floors ^ 16'h00FF;
            abort_btn = (i == at);
            cpu_halt = (i == at);
            tick();
        end
        is_init_floors = 1'b0; abort_btn = 1'b0; cpu_halt = 1'b0;
        m_state = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_rst", cpu_rst_n, 1'b0);
        check("abort_flags", {done, err}, 2'b00);
        check("abort_cycles", run_cycles, m_cycles);
        check("abort_lb", last_broken, m_lb);
        check("abort_disp", disp_data, {m_floors, m_res});
    endtask

    // monitor: pops one prediction for every rising done or err
    initial begin
        logic prev_done, prev_err;
        exp_t e;
        prev_done = 1'b0; prev_err = 1'b0;
        forever begin
            @(posedge in_clk);
            #2;
            if (in_rst && ((done && !prev_done) || (err && !prev_err))) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_unexpected: got done=%0b err=%0b expected no event", done, err);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_done", done, e.done);
                    check("mon_err", err, !e.done);
                    check("mon_code", err_code, e.code);
                    check("mon_cycles", run_cycles, e.cycles);
                    check("mon_lb", last_broken, e.lb);
                    check("mon_disp", disp_data, e.disp);
                end
            end
            prev_done = done;
            prev_err = err;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        in_rst = 1'b0; in_data = 16'd0; is_init_floors = 1'b0; is_init_resistance = 1'b0;
        start_btn = 1'b0; abort_btn = 1'b0; cpu_halt = 1'b0; cpu_last_broken = 1'b0;
        cpu_attempt_count = 32'd0; cpu_broken_count = 32'd0;
        model_reset();
        repeat (3) tick();
        check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        check("rst_flags", {busy, done, err, last_broken, err_code}, 32'd0);
        check("rst_cycles", run_cycles, 32'd0);
        check("rst_cfg", {cfg_floors, cfg_resistance}, 32'd0);
        check("rst_disp", disp_data, 32'd0);
        in_rst = 1'b1;
        tick();

        // missing configuration, ignored start in ERR, recovery by load
        load_floors(16'd100);
        do_run(10, 32'd1, 32'd1, 1'b0);
        repeat (3) tick();
        check("err1_rst_low", cpu_rst_n, 1'b0);
        do_run(10, 32'd1, 32'd1, 1'b0);
        load_res(16'd37);

        do_run(50, 32'd8, 32'd3, 1'b1);
        check("basic_disp", disp_data, 32'h00080003);
        check("basic_cycles", run_cycles, 32'd50);

        abort_run(10);
        do_run(TO, 32'h0001_2345, 32'h0000_0777, 1'b0);
        do_run(TO + 5, 32'd0, 32'd0, 1'b0);
        load_res(16'd37);

        load_floors(16'd0);
        load_res(16'd5);
        do_run(10, 32'd1, 32'd1, 1'b0);
        load_floors(16'd100);

        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                load_floors(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            end else if (r == 2) begin
                load_res(16'($urandom));
            end else if (r <= 8) begin
                do_run($urandom_range(1, TO + 3), $urandom, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                repeat (2) tick();
            end
            tick();
        end

        // reset between edges mid-run, start held high across release
        load_floors(16'd9);
        load_res(16'd4);
        press_start();
        repeat (RH + 5) tick();
        check("pre_rst_running", cpu_rst_n, 1'b1);
        #3 in_rst = 1'b0;
        #1;
        check("mid_rst_cpu", cpu_rst_n, 1'b0);
        check("mid_rst_flags", {busy, done, err, last_broken, err_code}, 32'd0);
        check("mid_rst_data", {cfg_floors, cfg_resistance}, 32'd0);
        check("mid_rst_cycles", run_cycles, 32'd0);
        model_reset();
        start_btn = 1'b1;
        repeat (2) tick();
        #3 in_rst = 1'b1;
        repeat (3) tick();
        check("rst_release_nostart", {busy, err, done, err_code}, 32'd0);
        start_btn = 1'b0;
        repeat (3) tick();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
